// File: rtl/mem_map_pkg.sv
// Data-port memory map shared by the core top and software headers: I/O page base,
// register offsets within the page, and STATUS bit positions.
package mem_map_pkg;

  localparam logic [31:0] IO_BASE_DEFAULT = 32'h0000_FF00;

  localparam logic [31:0] OFS_TX_DATA = 32'h0000_0000;
  localparam logic [31:0] OFS_STATUS  = 32'h0000_0004;
  localparam logic [31:0] OFS_CYCLE   = 32'h0000_0008;

  localparam int ST_EMPTY = 0;
  localparam int ST_FULL  = 1;
  localparam int ST_OVF   = 2;

  typedef enum logic [1:0] {
    REG_TX_DATA,
    REG_STATUS,
    REG_CYCLE,
    REG_NONE
  } io_reg_e;

  // Byte-lane bits of the offset are ignored: all accesses are whole words.
  function automatic io_reg_e decode_io(input logic [31:0] offset);
    io_reg_e r;
    r = REG_NONE;
    case ({offset[31:2], 2'b00})
      OFS_TX_DATA: r = REG_TX_DATA;
      OFS_STATUS:  r = REG_STATUS;
      OFS_CYCLE:   r = REG_CYCLE;
      default:     r = REG_NONE;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/tx_fifo.sv
// Generic power-of-two FIFO; push visible at head one cycle later, head reads 0 when empty.
// A push into a full FIFO is accepted only if a pop happens on the same edge.
module tx_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             arst_n,
  input  logic             push_vld,
  input  logic [WIDTH-1:0] push_dat,
  input  logic             pop_rdy,
  output logic [WIDTH-1:0] head_dat,
  output logic             full,
  output logic             empty
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    wr_ptr;
  logic [PW:0]      count;
  logic             do_pop;
  logic             do_push;

  assign empty    = (count == '0);
  assign full     = (count == (PW+1)'(DEPTH));
  assign do_pop   = pop_rdy && !empty;
  assign do_push  = push_vld && (!full || do_pop);
  assign head_dat = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage is never read while empty, so it needs no reset.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_dat;
  end

endmodule

// File: rtl/data_mem_responder.sv
// Data-port responder: word RAM plus I/O page (TX FIFO, STATUS, CYCLE); readdata is zero-latency.
// io_data/io_valid stream holds while io_ready is low; TX writes to a full FIFO are dropped and flagged.
module data_mem_responder
  import mem_map_pkg::*;
#(
  parameter int          MEM_WORDS  = 64,
  parameter int          FIFO_DEPTH = 4,
  parameter logic [31:0] IO_BASE    = IO_BASE_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        memwrite,
  input  logic [31:0] addr,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic [31:0] io_data,
  output logic        io_valid,
  input  logic        io_ready,
  output logic        fifo_full
);

  localparam int AW = $clog2(MEM_WORDS);

  logic [31:0]   ram [MEM_WORDS];
  logic [AW-1:0] ram_idx;
  logic          is_io;
  io_reg_e       io_reg;
  logic          fifo_empty;
  logic          pop;
  logic          tx_wr;
  logic          ovf_set;
  logic          ovf_clr;
  logic          cyc_clr;
  logic          overflow;
  logic [31:0]   cycle_cnt;
  logic [31:0]   status;

  assign is_io   = (addr >= IO_BASE);
  assign io_reg  = decode_io(addr - IO_BASE);
  assign ram_idx = addr[AW+1:2];

  assign io_valid = !fifo_empty;
  assign pop      = io_valid && io_ready;
  assign tx_wr    = memwrite && is_io && (io_reg == REG_TX_DATA);
  // A full FIFO still takes the word when the consumer pops on the same edge.
  assign ovf_set  = tx_wr && fifo_full && !pop;
  assign ovf_clr  = memwrite && is_io && (io_reg == REG_STATUS) && writedata[ST_OVF];
  assign cyc_clr  = memwrite && is_io && (io_reg == REG_CYCLE);

  tx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (32)
  ) u_tx_fifo (
    .clk      (clk),
    .arst_n   (reset),
    .push_vld (tx_wr),
    .push_dat (writedata),
    .pop_rdy  (pop),
    .head_dat (io_data),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (memwrite && !is_io) ram[ram_idx] <= writedata;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      overflow  <= 1'b0;
      cycle_cnt <= '0;
    end else begin
      if (ovf_set)      overflow <= 1'b1;
      else if (ovf_clr) overflow <= 1'b0;
      cycle_cnt <= cyc_clr ? '0 : cycle_cnt + 32'd1;
    end
  end

  always_comb begin
    status           = '0;
    status[ST_EMPTY] = fifo_empty;
    status[ST_FULL]  = fifo_full;
    status[ST_OVF]   = overflow;
  end

  always_comb begin
    readdata = '0;
    if (is_io) begin
      case (io_reg)
        REG_STATUS: readdata = status;
        REG_CYCLE:  readdata = cycle_cnt;
        default:    readdata = '0;
      endcase
    end else begin
      readdata = ram[ram_idx];
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: queue/array reference model checked every cycle, plus literal probes.
module tb_data_mem_responder;

  localparam int          MW  = 64;
  localparam int          FD  = 4;
  localparam int          AW  = $clog2(MW);
  localparam logic [31:0] IOB = 32'h0000_FF00;

  localparam int P_NONE = 0;
  localparam int P_RD   = 1;
  localparam int P_DAT  = 2;
  localparam int P_VLD  = 3;
  localparam int P_FULL = 4;

  logic        clk;
  logic        reset;
  logic        memwrite;
  logic [31:0] addr;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [31:0] io_data;
  logic        io_valid;
  logic        io_ready;
  logic        fifo_full;

  data_mem_responder #(
    .MEM_WORDS  (MW),
    .FIFO_DEPTH (FD),
    .IO_BASE    (IOB)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .memwrite  (memwrite),
    .addr      (addr),
    .writedata (writedata),
    .readdata  (readdata),
    .io_data   (io_data),
    .io_valid  (io_valid),
    .io_ready  (io_ready),
    .fifo_full (fifo_full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  int          probe_sel  = P_NONE;
  logic [31:0] probe_exp  = '0;
  string       probe_name = "";

  // Reference model state
  logic [31:0] mram [MW];
  bit          mval [MW];
  logic [31:0] mq [$];
  bit          movf;
  logic [31:0] mcyc;
  bit          m_pop;
  bit          m_accept;
  logic [31:0] m_off;

  function automatic logic [31:0] reg_index(input logic [31:0] a);
    logic [31:0] off;
    off = a - IOB;
    return {2'b00, off[31:2]};
  endfunction

  function automatic logic [31:0] model_read(input logic [31:0] a);
    logic [31:0] w;
    if (a < IOB) return mram[a[AW+1:2]];
    w = reg_index(a);
    if (w == 1) return {29'b0, movf, mq.size() == FD, mq.size() == 0};
    if (w == 2) return mcyc;
    return 32'h0;
  endfunction

  always @(posedge clk) begin
    if (memwrite && addr < IOB) begin
      mram[addr[AW+1:2]] = writedata;
      mval[addr[AW+1:2]] = 1'b1;
    end
  end

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      mq.delete();
      movf = 1'b0;
      mcyc = 32'h0;
    end else begin
      m_off    = (memwrite && addr >= IOB) ? reg_index(addr) : 32'hFFFF_FFFF;
      m_pop    = (mq.size() > 0) && io_ready;
      m_accept = (mq.size() < FD) || m_pop;
      if (m_pop) void'(mq.pop_front());
      if (m_off == 0) begin
        if (m_accept) mq.push_back(writedata);
        else          movf = 1'b1;
      end
      if (m_off == 1 && writedata[2] && !(m_off == 0 && !m_accept)) movf = 1'b0;
      mcyc = (m_off == 2) ? 32'h0 : mcyc + 32'd1;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    chk("io_valid", {31'b0, io_valid}, {31'b0, mq.size() != 0});
    chk("io_data", io_data, (mq.size() != 0) ? mq[0] : 32'h0);
    chk("fifo_full", {31'b0, fifo_full}, {31'b0, mq.size() == FD});
    if (addr >= IOB || mval[addr[AW+1:2]]) chk("readdata", readdata, model_read(addr));
    case (probe_sel)
      P_RD:    chk(probe_name, readdata, probe_exp);
      P_DAT:   chk(probe_name, io_data, probe_exp);
      P_VLD:   chk(probe_name, {31'b0, io_valid}, probe_exp);
      P_FULL:  chk(probe_name, {31'b0, fifo_full}, probe_exp);
      default: ;
    endcase
  end

  task automatic cyc(input logic we, input logic [31:0] a, input logic [31:0] wd, input logic rdy,
                     input int psel = P_NONE, input logic [31:0] pexp = 32'h0,
                     input string pname = "");
    memwrite   = we;
    addr       = a;
    writedata  = wd;
    io_ready   = rdy;
    probe_sel  = psel;
    probe_exp  = pexp;
    probe_name = pname;
    @(posedge clk);
    #1;
    probe_sel = P_NONE;
  endtask

  initial begin
    reset     = 1'b0;
    memwrite  = 1'b0;
    addr      = '0;
    writedata = '0;
    io_ready  = 1'b0;
    @(posedge clk);
    #1;
    cyc(0, IOB + 4, 0, 0, P_RD, 32'h1, "reset_status");
    cyc(0, IOB + 8, 0, 0, P_RD, 32'h0, "reset_cycle");
    reset = 1'b1;

    // RAM: basic, byte-offset ignored, aliasing, read-old-on-write
    cyc(1, 32'h10, 32'h1234_5678, 0);
    cyc(0, 32'h10, 0, 0, P_RD, 32'h1234_5678, "ram_read");
    cyc(0, 32'h13, 0, 0, P_RD, 32'h1234_5678, "ram_byteoff");
    cyc(0, 32'h10 + 4 * MW, 0, 0, P_RD, 32'h1234_5678, "ram_alias");
    cyc(1, 32'h10, 32'hCAFE_F00D, 0, P_RD, 32'h1234_5678, "ram_old_on_write");
    cyc(0, 32'h10, 0, 0, P_RD, 32'hCAFE_F00D, "ram_new");

    // Fill, overflow, drain
    for (int i = 0; i < 4; i++) cyc(1, IOB, 32'hA + i, 0);
    cyc(0, IOB + 4, 0, 0, P_RD, 32'h2, "status_full");
    cyc(0, IOB, 0, 0, P_FULL, 32'h1, "fifo_full_flag");
    cyc(1, IOB, 32'hE, 0);
    cyc(0, IOB + 4, 0, 0, P_RD, 32'h6, "status_overflow");
    cyc(0, IOB, 0, 0, P_RD, 32'h0, "txdata_reads_zero");
    for (int i = 0; i < 4; i++) cyc(0, 0, 0, 1, P_DAT, 32'hA + i, "drain_order");
    cyc(0, 0, 0, 1, P_VLD, 32'h0, "drained_valid");

    // Clear overflow
    cyc(1, IOB + 4, 32'h4, 0);
    cyc(0, IOB + 4, 0, 0, P_RD, 32'h1, "overflow_cleared");
    cyc(0, IOB + 12, 0, 0, P_RD, 32'h0, "unmapped_zero");

    // Full + push + pop on the same edge
    for (int i = 1; i <= 4; i++) cyc(1, IOB, i, 0);
    cyc(1, IOB, 32'hF, 1, P_DAT, 32'h1, "pushpop_head");
    cyc(0, IOB + 4, 0, 0, P_RD, 32'h2, "pushpop_no_ovf");
    cyc(0, 0, 0, 1, P_DAT, 32'h2, "pushpop_d2");
    cyc(0, 0, 0, 1, P_DAT, 32'h3, "pushpop_d3");
    cyc(0, 0, 0, 1, P_DAT, 32'h4, "pushpop_d4");
    cyc(0, 0, 0, 1, P_DAT, 32'hF, "pushpop_last");
    cyc(0, 0, 0, 1, P_VLD, 32'h0, "pushpop_empty");

    // Cycle counter clear and advance
    cyc(1, IOB + 8, 32'h55, 0);
    cyc(0, IOB + 8, 0, 0, P_RD, 32'h0, "cycle_cleared");
    repeat (9) cyc(0, IOB + 8, 0, 0);
    cyc(0, IOB + 8, 0, 0, P_RD, 32'd10, "cycle_plus10");

    // Asynchronous reset with queued words
    for (int i = 0; i < 3; i++) cyc(1, IOB, 32'h100 + i, 0);
    reset = 1'b0;
    cyc(0, IOB + 8, 0, 0, P_VLD, 32'h0, "async_rst_valid");
    cyc(0, IOB + 8, 0, 0, P_RD, 32'h0, "async_rst_cycle");
    reset = 1'b1;
    repeat (4) cyc(0, IOB + 4, 0, 1);
    cyc(0, IOB + 4, 0, 1, P_RD, 32'h1, "post_reset_status");

    // Randomized traffic
    for (int i = 0; i < 800; i++) begin
      int          r;
      logic [31:0] a;
      logic        rdy;
      r = $urandom_range(0, 9);
      if (r < 5)      a = $urandom_range(0, 32'h1FF);
      else if (r < 9) a = IOB + $urandom_range(0, 4) * 4 + $urandom_range(0, 3);
      else            a = $urandom;
      rdy = ((i / 50) % 2 == 1) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      cyc($urandom_range(0, 1) == 1, a, $urandom, rdy);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
